// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART receive packet path: FSM state
//               encoding, drop causes, sync byte default and baud tick counts.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef logic [2:0] state_t;
   typedef logic [1:0] drop_cause_t;

   localparam state_t c_ST_IDLE    = 3'd0;
   localparam state_t c_ST_LEN     = 3'd1;
   localparam state_t c_ST_PAYLOAD = 3'd2;
   localparam state_t c_ST_CHK     = 3'd3;
   localparam state_t c_ST_DELIVER = 3'd4;

   localparam drop_cause_t DROP_FRAME   = 2'd0;
   localparam drop_cause_t DROP_LEN     = 2'd1;
   localparam drop_cause_t DROP_CHK     = 2'd2;
   localparam drop_cause_t DROP_TIMEOUT = 2'd3;

   localparam logic [7:0] c_SYNC_BYTE_DEF = 8'hA5;

   localparam int c_BAUD_TICK_FULL = 10416;
   localparam int c_BAUD_TICK_HALF = 5208;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkt_buf
// Description : DEPTH x 8 payload register file, one synchronous write port
//               and one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pkt_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] r_mem [DEPTH];

   // Storage only; the controller gates the read data, so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule : uart_pkt_buf
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkt_ctrl
// Description : Sequences the UART byte receiver, parses sync/length/payload/
//               XOR checksum and releases checked payloads on a valid/ready
//               stream. Define UART_PKT_STATS_EN to add ok/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_ctrl
   import uart_pkg::*;
#(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SYNC_BYTE   = c_SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYC = 312480
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        enable,
   input  logic        rx_busy,
   input  logic        rx_done,
   input  logic        rx_err,
   input  logic [7:0]  rx_data,
   output logic        rx_en,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   input  logic        out_ready,
   output logic        pkt_ok,
   output logic        pkt_drop,
`ifdef UART_PKT_STATS_EN
   output logic [15:0] ok_cnt,
   output logic [15:0] drop_cnt,
`endif
   output logic [1:0]  drop_cause
);

   localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int c_TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      c_MAX_LEN  = 8'(MAX_LEN);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_len;
   logic [7:0]        r_idx;
   logic [7:0]        r_rd;
   logic [7:0]        r_chk;
   logic [c_TW-1:0]   r_timer;
   logic              r_rx_en;
   logic              r_pkt_ok;
   logic              r_pkt_drop;
   drop_cause_t       r_drop_cause;

   logic              w_ok;
   logic              w_drop;
   drop_cause_t       w_cause;
   logic              w_len_ld;
   logic              w_pay_ld;
   logic              w_deliver;
   logic              w_hs;
   logic              w_rd_last;
   logic [7:0]        w_rd_data;
   logic              w_unused_busy;

   assign w_unused_busy = rx_busy;

   assign w_deliver = (r_state == c_ST_DELIVER);
   assign w_hs      = w_deliver && out_ready;
   assign w_rd_last = (r_rd == (r_len - 8'd1));

   always_comb begin
      w_state_nxt = r_state;
      w_ok        = 1'b0;
      w_drop      = 1'b0;
      w_cause     = r_drop_cause;
      w_len_ld    = 1'b0;
      w_pay_ld    = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (enable && rx_done && (rx_data == SYNC_BYTE)) begin
               w_state_nxt = c_ST_LEN;
            end
         end
         c_ST_LEN, c_ST_PAYLOAD, c_ST_CHK: begin
            // Losing enable abandons a partial packet without reporting it.
            if (!enable) begin
               w_state_nxt = c_ST_IDLE;
            end else if (rx_err) begin
               w_drop      = 1'b1;
               w_cause     = DROP_FRAME;
               w_state_nxt = c_ST_IDLE;
            end else if (rx_done) begin
               if (r_state == c_ST_LEN) begin
                  if ((rx_data == 8'd0) || (rx_data > c_MAX_LEN)) begin
                     w_drop      = 1'b1;
                     w_cause     = DROP_LEN;
                     w_state_nxt = c_ST_IDLE;
                  end else begin
                     w_len_ld    = 1'b1;
                     w_state_nxt = c_ST_PAYLOAD;
                  end
               end else if (r_state == c_ST_PAYLOAD) begin
                  w_pay_ld = 1'b1;
                  if (r_idx == (r_len - 8'd1)) begin
                     w_state_nxt = c_ST_CHK;
                  end
               end else if (rx_data == r_chk) begin
                  w_ok        = 1'b1;
                  w_state_nxt = c_ST_DELIVER;
               end else begin
                  w_drop      = 1'b1;
                  w_cause     = DROP_CHK;
                  w_state_nxt = c_ST_IDLE;
               end
            end else if (r_timer == c_TMO_LAST) begin
               w_drop      = 1'b1;
               w_cause     = DROP_TIMEOUT;
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_DELIVER: begin
            if (w_hs && w_rd_last) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state      <= c_ST_IDLE;
         r_rx_en      <= 1'b0;
         r_pkt_ok     <= 1'b0;
         r_pkt_drop   <= 1'b0;
         r_drop_cause <= DROP_FRAME;
      end else begin
         r_state    <= w_state_nxt;
         r_rx_en    <= enable && (w_state_nxt != c_ST_DELIVER);
         r_pkt_ok   <= w_ok;
         r_pkt_drop <= w_drop;
         if (w_drop) begin
            r_drop_cause <= w_cause;
         end
      end
   end

   // The length byte seeds the checksum, so it is covered by the XOR too.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_len   <= 8'd0;
         r_idx   <= 8'd0;
         r_rd    <= 8'd0;
         r_chk   <= 8'd0;
         r_timer <= '0;
      end else begin
         if (w_len_ld) begin
            r_len <= rx_data;
            r_chk <= rx_data;
            r_idx <= 8'd0;
         end else if (w_pay_ld) begin
            r_chk <= r_chk ^ rx_data;
            r_idx <= r_idx + 8'd1;
         end
         if (w_ok) begin
            r_rd <= 8'd0;
         end else if (w_hs) begin
            r_rd <= r_rd + 8'd1;
         end
         if ((w_state_nxt != r_state) || rx_done) begin
            r_timer <= '0;
         end else if ((r_state == c_ST_LEN) || (r_state == c_ST_PAYLOAD) ||
                      (r_state == c_ST_CHK)) begin
            r_timer <= r_timer + 1'b1;
         end else begin
            r_timer <= '0;
         end
      end
   end

   uart_pkt_buf #(
      .DEPTH (MAX_LEN),
      .AW    (c_AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (w_pay_ld),
      .wr_addr (r_idx[c_AW-1:0]),
      .wr_data (rx_data),
      .rd_addr (r_rd[c_AW-1:0]),
      .rd_data (w_rd_data)
   );

`ifdef UART_PKT_STATS_EN
   logic [15:0] r_ok_cnt;
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_ok_cnt   <= 16'd0;
         r_drop_cnt <= 16'd0;
      end else begin
         if (w_ok && (r_ok_cnt != 16'hFFFF)) begin
            r_ok_cnt <= r_ok_cnt + 16'd1;
         end
         if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

   assign ok_cnt   = r_ok_cnt;
   assign drop_cnt = r_drop_cnt;
`endif

   assign rx_en      = r_rx_en;
   assign pkt_ok     = r_pkt_ok;
   assign pkt_drop   = r_pkt_drop;
   assign drop_cause = r_drop_cause;
   assign out_valid  = w_deliver;
   assign out_data   = w_deliver ? w_rd_data : 8'd0;
   assign out_last   = w_deliver && w_rd_last;

endmodule : uart_rx_pkt_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_pkt_ctrl
// Description : Scoreboard bench for uart_rx_pkt_ctrl driving receiver
//               done/err pulses directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pkt_ctrl;

   localparam int c_MAX_LEN = 16;
   localparam int c_TMO     = 100;
   localparam logic [1:0] c_K_OK   = 2'd0;
   localparam logic [1:0] c_K_DROP = 2'd1;
   localparam logic [1:0] c_K_BEAT = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
      logic       last;
      logic [1:0] cause;
   } exp_t;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       enable = 1'b0;
   logic       rx_busy = 1'b0;
   logic       rx_done = 1'b0;
   logic       rx_err = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       out_ready = 1'b0;
   logic       rx_en;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       pkt_ok;
   logic       pkt_drop;
   logic [1:0] drop_cause;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];

   uart_rx_pkt_ctrl #(
      .MAX_LEN     (c_MAX_LEN),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (c_TMO)
   ) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .enable     (enable),
      .rx_busy    (rx_busy),
      .rx_done    (rx_done),
      .rx_err     (rx_err),
      .rx_data    (rx_data),
      .rx_en      (rx_en),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .pkt_ok     (pkt_ok),
      .pkt_drop   (pkt_drop),
      .drop_cause (drop_cause)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] kind, input logic [7:0] data,
                       input logic last, input logic [1:0] cause);
      exp_t e;
      e.kind  = kind;
      e.data  = data;
      e.last  = last;
      e.cause = cause;
      q.push_back(e);
   endtask

   task automatic expect_evt(input logic [1:0] kind, input logic [7:0] data,
                             input logic last, input logic [1:0] cause, input string name);
      exp_t e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_%s: got kind %0d data %0h expected no event", name, kind, data);
      end else begin
         e = q.pop_front();
         check({name, "_kind"}, 32'(kind), 32'(e.kind));
         if (e.kind == c_K_DROP && kind == c_K_DROP) begin
            check({name, "_cause"}, 32'(cause), 32'(e.cause));
         end
         if (e.kind == c_K_BEAT && kind == c_K_BEAT) begin
            check({name, "_data"}, 32'(data), 32'(e.data));
            check({name, "_last"}, 32'(last), 32'(e.last));
         end
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports an event.
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;

   always @(negedge clk) begin
      if (pkt_ok && pkt_drop) check("ok_drop_overlap", 32'(pkt_ok & pkt_drop), 32'd0);
      if (pkt_ok) expect_evt(c_K_OK, 8'd0, 1'b0, 2'd0, "pkt_ok");
      if (pkt_drop) expect_evt(c_K_DROP, 8'd0, 1'b0, drop_cause, "pkt_drop");
      if (out_valid && stall_prev) begin
         check("stall_data", 32'(out_data), 32'(prev_data));
         check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) expect_evt(c_K_BEAT, out_data, out_last, 2'd0, "beat");
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick();
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_en"},      32'(rx_en),      32'd0);
      check({tag, "_out_valid"},  32'(out_valid),  32'd0);
      check({tag, "_out_data"},   32'(out_data),   32'd0);
      check({tag, "_out_last"},   32'(out_last),   32'd0);
      check({tag, "_pkt_ok"},     32'(pkt_ok),     32'd0);
      check({tag, "_pkt_drop"},   32'(pkt_drop),   32'd0);
      check({tag, "_drop_cause"}, 32'(drop_cause), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      enable    = 1'b1;
      out_ready = 1'b1;
      #12;
      check_all_zero("reset");
      tick();
      arst_n = 1'b1;
      tick();
      check("rx_en_after_reset", 32'(rx_en), 32'd1);

      // Noise before sync, single-byte packet
      push(c_K_OK, 8'h00, 1'b0, 2'd0);
      push(c_K_BEAT, 8'h7E, 1'b1, 2'd0);
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
      send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
      repeat (4) tick();

      // Three-byte packet, rx_en low while delivering
      push(c_K_OK, 8'h00, 1'b0, 2'd0);
      push(c_K_BEAT, 8'h11, 1'b0, 2'd0);
      push(c_K_BEAT, 8'h22, 1'b0, 2'd0);
      push(c_K_BEAT, 8'h33, 1'b1, 2'd0);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      check("deliver_rx_en", 32'(rx_en), 32'd0);
      check("deliver_valid", 32'(out_valid), 32'd1);
      repeat (3) tick();
      check("post_deliver_valid", 32'(out_valid), 32'd0);
      check("post_deliver_rx_en", 32'(rx_en), 32'd1);
      repeat (2) tick();

      // Bad checksum (correct would be 32)
      push(c_K_DROP, 8'h00, 1'b0, 2'd2);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      send_byte(8'h20); send_byte(8'h00);
      repeat (3) tick();

      // Zero and oversize lengths
      push(c_K_DROP, 8'h00, 1'b0, 2'd1);
      send_byte(8'hA5); send_byte(8'h00);
      repeat (2) tick();
      push(c_K_DROP, 8'h00, 1'b0, 2'd1);
      send_byte(8'hA5); send_byte(8'h11);
      repeat (3) tick();

      // Framing error mid-payload
      push(c_K_DROP, 8'h00, 1'b0, 2'd0);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      tick();
      rx_err = 1'b1;
      tick();
      rx_err = 1'b0;
      repeat (3) tick();

      // Timeout: drop lands exactly c_TMO cycles after the last done pulse
      push(c_K_DROP, 8'h00, 1'b0, 2'd3);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      n = 0;
      do begin
         tick();
         n++;
      end while (!pkt_drop && n < 3 * c_TMO);
      check("timeout_latency", 32'(n), 32'(c_TMO));
      repeat (3) tick();

      // Enable dropped mid-packet: silent abort, later bytes ignored in IDLE
      send_byte(8'hA5); send_byte(8'h02);
      enable = 1'b0;
      repeat (2) tick();
      check("disabled_rx_en", 32'(rx_en), 32'd0);
      enable = 1'b1;
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
      repeat (3) tick();

      // Back-pressure: 5 stalled cycles per beat
      out_ready = 1'b0;
      push(c_K_OK, 8'h00, 1'b0, 2'd0);
      push(c_K_BEAT, 8'hAA, 1'b0, 2'd0);
      push(c_K_BEAT, 8'hBB, 1'b0, 2'd0);
      push(c_K_BEAT, 8'hCC, 1'b1, 2'd0);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'hAA);
      send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDE);
      for (int b = 0; b < 3; b++) begin
         repeat (5) tick();
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      repeat (2) tick();
      check("stall_done_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset in the middle of delivery
      push(c_K_OK, 8'h00, 1'b0, 2'd0);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55);
      send_byte(8'h66); send_byte(8'h31);
      tick();
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      #2;
      arst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      tick();
      arst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post_reset_valid", 32'(out_valid), 32'd0);
      check("post_reset_rx_en", 32'(rx_en), 32'd1);

      repeat (5) tick();
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_uart_rx_pkt_ctrl
`default_nettype wire
